fetch_unit: RTL and testbench

- Instruction-fetch front end sitting directly upstream of imem.
- Owns the program counter and drives imem's word-aligned address.
- Captures imem's combinational read data into a registered fetch slot, presented to decode with a valid/ready handshake.
- Handles PC redirects (branch/jump) and flags misaligned or out-of-range fetch targets as faults.

---
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, addresses imem, and registers the
// fetched word into a valid/ready slot for decode, with redirect and fault handling.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 64,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        redir_valid,
    input  logic [31:0] redir_target,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_addr,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        ST_RUN,
        ST_FAULT
    } state_e;

    localparam logic [1:0]  CAUSE_NONE      = 2'b00;
    localparam logic [1:0]  CAUSE_MISALIGN  = 2'b01;
    localparam logic [1:0]  CAUSE_RANGE     = 2'b10;
    localparam logic [29:0] MEM_WORDS_LIMIT = 30'(MEM_WORDS);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        fault_q, fault_d;
    logic [1:0]  fault_cause_q, fault_cause_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic slot_free;
    logic pc_in_range;

    assign slot_free   = !if_valid_q || if_ready;
    assign pc_in_range = pc_q[31:2] < MEM_WORDS_LIMIT;

    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block can infer a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        fault_d       = fault_q;
        fault_cause_d = fault_cause_q;
        fault_addr_d  = fault_addr_q;
        fetch_count_d = fetch_count_q;

        // A handshake this cycle is consumed by decode even if a redirect squashes the slot.
        if (if_valid_q && if_ready) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end

        if (redir_valid) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
            pc_d       = redir_target;
            if (redir_target[1:0] != 2'b00) begin
                state_d       = ST_FAULT;
                fault_d       = 1'b1;
                fault_cause_d = CAUSE_MISALIGN;
                fault_addr_d  = redir_target;
            end else begin
                state_d       = ST_RUN;
                fault_d       = 1'b0;
                fault_cause_d = CAUSE_NONE;
            end
        end else if (state_q == ST_RUN && slot_free) begin
            if (pc_q[1:0] != 2'b00 || !pc_in_range) begin
                state_d       = ST_FAULT;
                fault_d       = 1'b1;
                fault_cause_d = (pc_q[1:0] != 2'b00) ? CAUSE_MISALIGN : CAUSE_RANGE;
                fault_addr_d  = pc_q;
                if_valid_d    = 1'b0;
                if_instr_d    = NOP_INSTR;
            end else begin
                if_instr_d = imem_rdata;
                if_pc_d    = pc_q;
                if_valid_d = 1'b1;
                pc_d       = pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_instr_q    <= NOP_INSTR;
            if_pc_q       <= 32'd0;
            fault_q       <= 1'b0;
            fault_cause_q <= CAUSE_NONE;
            fault_addr_q  <= 32'd0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            fault_q       <= fault_d;
            fault_cause_q <= fault_cause_d;
            fault_addr_q  <= fault_addr_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign fault       = fault_q;
    assign fault_cause = fault_cause_q;
    assign fault_addr  = fault_addr_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of per-cycle vectors with hand-computed
// expectations, plus a bounded end-of-memory streaming sequence.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_target = 32'd0;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fault_addr;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [64];
    assign imem_rdata = mem[imem_addr[7:2]];

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .MEM_WORDS (64),
        .NOP_INSTR (NOP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .fault        (fault),
        .fault_cause  (fault_cause),
        .fault_addr   (fault_addr),
        .fetch_count  (fetch_count)
    );

    typedef struct {
        int          reps;
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rt;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_addr;
        logic        e_fault;
        logic [1:0]  e_cause;
        logic [31:0] e_faddr;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input int reps, input logic rst, input logic rdy, input logic rv,
                       input logic [31:0] rt, input logic e_valid, input logic [31:0] e_instr,
                       input logic [31:0] e_pc, input logic [31:0] e_addr, input logic e_fault,
                       input logic [1:0] e_cause, input logic [31:0] e_faddr,
                       input logic [31:0] e_cnt);
        vec_t v;
        v.reps = reps; v.rst = rst; v.rdy = rdy; v.rv = rv; v.rt = rt;
        v.e_valid = e_valid; v.e_instr = e_instr; v.e_pc = e_pc; v.e_addr = e_addr;
        v.e_fault = e_fault; v.e_cause = e_cause; v.e_faddr = e_faddr; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    initial begin
        int cyc;
        int bad_data;

        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[0] = 32'h0000_000F;
        mem[1] = 32'h0000_00F0;
        mem[2] = 32'h0000_0F00;
        mem[7] = 32'hF000_0000;

        //   reps rst rdy rv target        valid instr          if_pc        addr         flt cause faddr        count
        // Reset, then streaming with ready held high.
        add(1,  1, 0, 0, 32'h0,        0, NOP,           32'h0,       32'h0,       0, 2'd0, 32'h0,       0);
        add(1,  0, 1, 0, 32'h0,        1, 32'h0000000F,  32'h0,       32'h4,       0, 2'd0, 32'h0,       0);
        add(1,  0, 1, 0, 32'h0,        1, 32'h000000F0,  32'h4,       32'h8,       0, 2'd0, 32'h0,       1);
        add(1,  0, 1, 0, 32'h0,        1, 32'h00000F00,  32'h8,       32'hC,       0, 2'd0, 32'h0,       2);
        add(1,  0, 1, 0, 32'h0,        1, 32'hA0000003,  32'hC,       32'h10,      0, 2'd0, 32'h0,       3);
        // Reset while streaming, then backpressure after the first fetch.
        add(1,  1, 1, 0, 32'h0,        0, NOP,           32'h0,       32'h0,       0, 2'd0, 32'h0,       0);
        add(1,  0, 1, 0, 32'h0,        1, 32'h0000000F,  32'h0,       32'h4,       0, 2'd0, 32'h0,       0);
        add(4,  0, 0, 0, 32'h0,        1, 32'h0000000F,  32'h0,       32'h4,       0, 2'd0, 32'h0,       0);
        add(1,  0, 1, 0, 32'h0,        1, 32'h000000F0,  32'h4,       32'h8,       0, 2'd0, 32'h0,       1);
        // Redirect concurrent with a handshake: transfer counts, slot squashed.
        add(1,  0, 1, 1, 32'h1C,       0, NOP,           32'h4,       32'h1C,      0, 2'd0, 32'h0,       2);
        add(1,  0, 1, 0, 32'h0,        1, 32'hF0000000,  32'h1C,      32'h20,      0, 2'd0, 32'h0,       2);
        // Misaligned redirect, sit in FAULT, re-fault with new address, aligned exit.
        add(1,  0, 1, 1, 32'hA,        0, NOP,           32'h1C,      32'hA,       1, 2'd1, 32'hA,       3);
        add(10, 0, 1, 0, 32'h0,        0, NOP,           32'h1C,      32'hA,       1, 2'd1, 32'hA,       3);
        add(1,  0, 1, 1, 32'h2,        0, NOP,           32'h1C,      32'h2,       1, 2'd1, 32'h2,       3);
        add(1,  0, 1, 1, 32'h4,        0, NOP,           32'h1C,      32'h4,       0, 2'd0, 32'h2,       3);
        add(1,  0, 1, 0, 32'h0,        1, 32'h000000F0,  32'h4,       32'h8,       0, 2'd0, 32'h2,       3);
        // Reset during backpressure.
        add(1,  0, 0, 0, 32'h0,        1, 32'h000000F0,  32'h4,       32'h8,       0, 2'd0, 32'h2,       3);
        add(1,  1, 0, 0, 32'h0,        0, NOP,           32'h0,       32'h0,       0, 2'd0, 32'h0,       0);
        // Run off the end of memory.
        add(1,  0, 1, 1, 32'hF8,       0, NOP,           32'h0,       32'hF8,      0, 2'd0, 32'h0,       0);
        add(1,  0, 1, 0, 32'h0,        1, 32'hA000003E,  32'hF8,      32'hFC,      0, 2'd0, 32'h0,       0);
        add(1,  0, 1, 0, 32'h0,        1, 32'hA000003F,  32'hFC,      32'h100,     0, 2'd0, 32'h0,       1);
        add(1,  0, 1, 0, 32'h0,        0, NOP,           32'hFC,      32'h100,     1, 2'd2, 32'h100,     2);
        add(3,  0, 1, 0, 32'h0,        0, NOP,           32'hFC,      32'h100,     1, 2'd2, 32'h100,     2);
        // Aligned redirect out of range: accepted, then range fault next cycle.
        add(1,  0, 1, 1, 32'h200,      0, NOP,           32'hFC,      32'h200,     0, 2'd0, 32'h100,     2);
        add(1,  0, 1, 0, 32'h0,        0, NOP,           32'hFC,      32'h200,     1, 2'd2, 32'h200,     2);
        // Reset while in FAULT.
        add(1,  1, 1, 0, 32'h0,        0, NOP,           32'h0,       32'h0,       0, 2'd0, 32'h0,       0);
        // Redirect under backpressure: no transfer counted, target fetched next cycle.
        add(1,  0, 1, 0, 32'h0,        1, 32'h0000000F,  32'h0,       32'h4,       0, 2'd0, 32'h0,       0);
        add(1,  0, 0, 1, 32'h8,        0, NOP,           32'h0,       32'h8,       0, 2'd0, 32'h0,       0);
        add(1,  0, 0, 0, 32'h0,        1, 32'h00000F00,  32'h8,       32'hC,       0, 2'd0, 32'h0,       0);

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                reset        = vecs[i].rst;
                if_ready     = vecs[i].rdy;
                redir_valid  = vecs[i].rv;
                redir_target = vecs[i].rt;
                @(posedge clk);
                #1;
                check($sformatf("v%0d.%0d valid", i, r),   32'(if_valid),    32'(vecs[i].e_valid));
                check($sformatf("v%0d.%0d instr", i, r),   if_instr,         vecs[i].e_instr);
                check($sformatf("v%0d.%0d if_pc", i, r),   if_pc,            vecs[i].e_pc);
                check($sformatf("v%0d.%0d addr", i, r),    imem_addr,        vecs[i].e_addr);
                check($sformatf("v%0d.%0d fault", i, r),   32'(fault),       32'(vecs[i].e_fault));
                check($sformatf("v%0d.%0d cause", i, r),   32'(fault_cause), 32'(vecs[i].e_cause));
                check($sformatf("v%0d.%0d faddr", i, r),   fault_addr,       vecs[i].e_faddr);
                check($sformatf("v%0d.%0d count", i, r),   fetch_count,      vecs[i].e_cnt);
            end
        end

        // Full sweep from reset: 64 words delivered in order, range fault on the 65th edge.
        reset        = 1'b1;
        if_ready     = 1'b0;
        redir_valid  = 1'b0;
        redir_target = 32'd0;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        if_ready = 1'b1;
        cyc      = 0;
        bad_data = 0;
        while (!fault && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (if_valid && if_instr !== mem[if_pc[7:2]]) bad_data++;
        end
        check("sweep fault reached", 32'(fault), 32'd1);
        check("sweep cycles", 32'(cyc), 32'd65);
        check("sweep data errors", 32'(bad_data), 32'd0);
        check("sweep count", fetch_count, 32'd64);
        check("sweep cause", 32'(fault_cause), 32'd2);
        check("sweep faddr", fault_addr, 32'h100);
        check("sweep valid", 32'(if_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
